// File: rtl/bcd_disp_mux.sv
// Four-digit multiplexed 7-segment driver for captured BCD values, with
// leading-zero blanking, per-digit decimal points and an overflow dash display.
module bcd_disp_mux #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_bcd [3:0],
    input  logic [3:0] i_dp,
    input  logic       i_ovf,
    input  logic       i_blank_en,
    output logic [3:0] o_an,
    output logic [7:0] o_seg,
    output logic [1:0] o_idx
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(REFRESH_DIV - 1);

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    logic [3:0]    bcd_q [3:0];
    logic [3:0]    bcd_d [3:0];
    logic [3:0]    dp_q, dp_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    oidx_q, oidx_d;
    logic          upper_zero_s;
    logic          blank_s;
    logic [3:0]    an_lit_s;

    // Next-state: capture, prescaler/index scan, and the output image for idx_q.
    always_comb begin
        bcd_d = bcd_q;
        dp_d  = dp_q;
        ovf_d = ovf_q;
        if (i_load) begin
            bcd_d = i_bcd;
            dp_d  = i_dp;
            ovf_d = i_ovf;
        end else begin
            bcd_d = bcd_q;
            dp_d  = dp_q;
            ovf_d = ovf_q;
        end

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + CW'(1);
            idx_d   = idx_q;
        end

        // Digit 0 always stays lit so a zero reading still shows "0".
        case (idx_q)
            2'd3:    upper_zero_s = (bcd_q[3] == 4'd0);
            2'd2:    upper_zero_s = (bcd_q[3] == 4'd0) && (bcd_q[2] == 4'd0);
            2'd1:    upper_zero_s = (bcd_q[3] == 4'd0) && (bcd_q[2] == 4'd0) &&
                                    (bcd_q[1] == 4'd0);
            default: upper_zero_s = 1'b0;
        endcase
        blank_s  = i_blank_en & ~ovf_q & upper_zero_s;
        an_lit_s = ~(4'b0001 << idx_q);

        if (blank_s) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end else if (ovf_q) begin
            an_d  = an_lit_s;
            seg_d = {~dp_q[idx_q], 7'h3F};
        end else begin
            an_d  = an_lit_s;
            seg_d = {~dp_q[idx_q], seg_encode(bcd_q[idx_q])};
        end
        oidx_d = idx_q;
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bcd_q   <= '{default: 4'd0};
            dp_q    <= 4'd0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
            oidx_q  <= 2'd0;
        end else begin
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            oidx_q  <= oidx_d;
        end
    end

    assign o_an  = an_q;
    assign o_seg = seg_q;
    assign o_idx = oidx_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Scoreboard bench for bcd_disp_mux at REFRESH_DIV=4: a cycle model pushes the
// expected outputs per edge, each test pops them and adds fixed-value spot checks.
module tb_bcd_disp_mux;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n, load, ovf, blank_en;
    logic [3:0] bcd [3:0];
    logic [3:0] dp;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] idx;

    always #5 clk = ~clk;

    bcd_disp_mux #(.REFRESH_DIV(DIV)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_bcd(bcd), .i_dp(dp),
        .i_ovf(ovf), .i_blank_en(blank_en), .o_an(an), .o_seg(seg), .o_idx(idx)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] idx;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    exp_t e;

    logic [3:0] m_bcd [3:0];
    logic [3:0] m_dp;
    logic       m_ovf;
    int         m_presc;
    int         m_idx;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
            4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
            4'd9: return 8'h90;  default: return 8'hBF;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t r;
        logic blank;
        blank = 1'b0;
        if (blank_en && !m_ovf && m_idx > 0) begin
            blank = 1'b1;
            for (int k = m_idx; k < 4; k++)
                if (m_bcd[k] != 4'd0) blank = 1'b0;
        end
        r.idx = m_idx[1:0];
        if (blank) begin
            r.an  = 4'hF;
            r.seg = 8'hFF;
        end else begin
            r.an = 4'hF;
            r.an[m_idx] = 1'b0;
            r.seg = m_ovf ? 8'hBF : enc(m_bcd[m_idx]);
            r.seg[7] = ~m_dp[m_idx];
        end
        return r;
    endfunction

    // One clock edge: push the expected output for this edge, advance the model.
    task automatic tick();
        if (!rst_n) sbq.push_back('{an: 4'hF, seg: 8'hFF, idx: 2'd0});
        else        sbq.push_back(model_out());
        if (!rst_n) begin
            m_bcd = '{default: 4'd0};
            m_dp = 4'd0; m_ovf = 1'b0; m_presc = 0; m_idx = 0;
        end else begin
            if (load) begin
                m_bcd = bcd; m_dp = dp; m_ovf = ovf;
            end
            if (m_presc == DIV - 1) begin
                m_presc = 0; m_idx = (m_idx + 1) % 4;
            end else begin
                m_presc = m_presc + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b1; ovf = 1'b1; dp = 4'hF; blank_en = 1'b0;
        bcd = '{4'd9, 4'd9, 4'd9, 4'd9};
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || an !== 4'hF || seg !== 8'hFF || idx !== 2'd0) begin
                bad++;
                $display("FAIL reset_hold: got an=%h seg=%h idx=%0d want an=F seg=FF idx=0", an, seg, idx);
            end
        end
        rst_n = 1'b1; load = 1'b0;
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e || an !== 4'hE || seg !== 8'hC0 || idx !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: got an=%h seg=%h idx=%0d want an=E seg=C0 idx=0", an, seg, idx);
        end
    endtask

    task automatic test_scan();
        logic [3:0] want_an;
        logic [7:0] want_seg;
        load = 1'b1; ovf = 1'b0; dp = 4'h0; blank_en = 1'b0;
        bcd = '{4'd1, 4'd2, 4'd3, 4'd4};
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL scan_load: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            case (idx)
                2'd0: begin want_an = 4'hE; want_seg = 8'h99; end
                2'd1: begin want_an = 4'hD; want_seg = 8'hB0; end
                2'd2: begin want_an = 4'hB; want_seg = 8'hA4; end
                default: begin want_an = 4'h7; want_seg = 8'hF9; end
            endcase
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || an !== want_an || seg !== want_seg) begin
                bad++;
                $display("FAIL scan: got an=%h seg=%h idx=%0d want an=%h seg=%h idx=%0d",
                         an, seg, idx, e.an, e.seg, e.idx);
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] want_an;
        logic [7:0] want_seg;
        load = 1'b1; blank_en = 1'b1; dp = 4'h0; ovf = 1'b0;
        bcd = '{4'd0, 4'd0, 4'd4, 4'd2};
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL blank_load: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            case (idx)
                2'd0: begin want_an = 4'hE; want_seg = 8'hA4; end
                2'd1: begin want_an = 4'hD; want_seg = 8'h99; end
                default: begin want_an = 4'hF; want_seg = 8'hFF; end
            endcase
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || an !== want_an || seg !== want_seg) begin
                bad++;
                $display("FAIL blank_0042: got an=%h seg=%h idx=%0d want an=%h seg=%h idx=%0d",
                         an, seg, idx, e.an, e.seg, e.idx);
            end
        end
        load = 1'b1; bcd = '{4'd0, 4'd0, 4'd0, 4'd0};
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL blank_load0: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            want_an  = (idx == 2'd0) ? 4'hE : 4'hF;
            want_seg = (idx == 2'd0) ? 8'hC0 : 8'hFF;
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || an !== want_an || seg !== want_seg) begin
                bad++;
                $display("FAIL blank_0000: got an=%h seg=%h idx=%0d want an=%h seg=%h idx=%0d",
                         an, seg, idx, e.an, e.seg, e.idx);
            end
        end
        blank_en = 1'b0;
    endtask

    task automatic test_ovf_invalid();
        logic [7:0] want_seg;
        load = 1'b1; ovf = 1'b1; dp = 4'h0; bcd = '{4'd1, 4'd2, 4'd3, 4'd4};
        blank_en = 1'b1;
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL ovf_load: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || seg !== 8'hBF || an !== ~(4'b0001 << idx)) begin
                bad++;
                $display("FAIL ovf_dash: got an=%h seg=%h idx=%0d want an=%h seg=BF", an, seg, idx, e.an);
            end
        end
        load = 1'b1; ovf = 1'b0; blank_en = 1'b0; bcd = '{4'd0, 4'hC, 4'd0, 4'd0};
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL invalid_load: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            want_seg = (idx == 2'd2) ? 8'hBF : 8'hC0;
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || seg !== want_seg) begin
                bad++;
                $display("FAIL invalid_digit: got seg=%h idx=%0d want seg=%h", seg, idx, want_seg);
            end
        end
    endtask

    task automatic test_dp_collision();
        int old_idx;
        load = 1'b1; ovf = 1'b0; dp = 4'b0010; bcd = '{4'd5, 4'd6, 4'd7, 4'd8};
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL dp_load: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || seg[7] !== (idx != 2'd1)) begin
                bad++;
                $display("FAIL dp: got seg=%h idx=%0d want seg=%h", seg, idx, e.seg);
            end
        end
        // Line up so the next edge is a prescaler wrap, then load on it.
        while (m_presc != DIV - 1) begin
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e) begin
                bad++; $display("FAIL align: got %h want %h", {an, seg, idx}, e);
            end
        end
        old_idx = m_idx;
        load = 1'b1; dp = 4'h0; bcd = '{4'd7, 4'd7, 4'd7, 4'd7};
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e || idx !== old_idx[1:0]) begin
            bad++; $display("FAIL collide_edge: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e || seg !== 8'hF8 || idx !== 2'((old_idx + 1) % 4)) begin
            bad++;
            $display("FAIL collide_next: got seg=%h idx=%0d want seg=F8 idx=%0d", seg, idx, (old_idx + 1) % 4);
        end
    endtask

    task automatic test_back_to_back();
        for (int v = 1; v <= 3; v++) begin
            load = 1'b1; dp = 4'h0;
            bcd = '{4'(v), 4'(v), 4'(v), 4'(v)};
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e) begin
                bad++; $display("FAIL b2b_load: got %h want %h", {an, seg, idx}, e);
            end
        end
        load = 1'b0;
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e || seg !== 8'hB0) begin
            bad++; $display("FAIL b2b_last_wins: got seg=%h want seg=B0", seg);
        end
    endtask

    task automatic test_reset_midscan();
        int budget;
        load = 1'b1; bcd = '{4'd9, 4'd8, 4'd7, 4'd6}; dp = 4'hF;
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e) begin
            bad++; $display("FAIL mid_load: got %h want %h", {an, seg, idx}, e);
        end
        load = 1'b0;
        budget = 0;
        while (idx !== 2'd2 && budget < 20) begin
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e) begin
                bad++; $display("FAIL mid_scan: got %h want %h", {an, seg, idx}, e);
            end
            budget++;
        end
        total++;
        if (idx !== 2'd2) begin
            bad++; $display("FAIL mid_wait: got idx=%0d want idx=2 within 20 cycles", idx);
        end
        rst_n = 1'b0;
        tick();
        e = sbq.pop_front(); total++;
        if ({an, seg, idx} !== e || an !== 4'hF || seg !== 8'hFF || idx !== 2'd0) begin
            bad++; $display("FAIL mid_reset: got an=%h seg=%h idx=%0d want an=F seg=FF idx=0", an, seg, idx);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            e = sbq.pop_front(); total++;
            if ({an, seg, idx} !== e || seg !== 8'hC0) begin
                bad++;
                $display("FAIL mid_cleared: got an=%h seg=%h idx=%0d want an=%h seg=C0", an, seg, idx, e.an);
            end
        end
    endtask

    initial begin
        m_bcd = '{default: 4'd0};
        m_dp = 4'd0; m_ovf = 1'b0; m_presc = 0; m_idx = 0;
        test_reset();
        test_scan();
        test_blanking();
        test_ovf_invalid();
        test_dp_collision();
        test_back_to_back();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
